output_port_arbiter: RTL and testbench

Round-robin wormhole arbiter that lets `N_IN` input `circular_Buffer` instances share one router output link. It pops flits from the granted buffer and forwards them as a registered flit stream to the downstream buffer. Once a HEAD flit wins, the grant stays locked on that input until the matching TAIL flit has been forwarded. It sits between the input buffers and the output link of a NoC router port and drives their `read_i` and the downstream `write_i`.

---
 rtl/output_port_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_output_port_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_port_arbiter.sv
// output_port_arbiter: round-robin wormhole arbiter that lets N_IN input
// buffers share one router output link. A HEAD flit wins the output and keeps
// it until the matching TAIL has been forwarded. Flits are forwarded as a
// registered stream (flit_o/valid_o) one cycle after the buffer is popped.
//
// Optional feature macro: OUT_ARB_PKT_CNT_EN
//   defined   -> pkt_cnt_o port and PKT_CNT_W-bit completed-packet counter exist
//   undefined -> no counter, no pkt_cnt_o port, otherwise identical behaviour
//
// The noc_pkg package carries the flit format shared with the input buffers.

package noc_pkg;

    // Flit type tag; INVALID is what an all-zero flit decodes to
    typedef enum logic [1:0] {
        INVALID = 2'b00,
        HEAD    = 2'b01,
        BODY    = 2'b10,
        TAIL    = 2'b11
    } flit_label_t;

    // Flit as stored in a circular_Buffer without virtual-channel fields
    typedef struct packed {
        flit_label_t flit_DataLabel;
        logic [31:0] data;
    } flit_Data_noVC;

endpackage

module output_port_arbiter
    import noc_pkg::*;
#(
    parameter int N_IN = 5
`ifdef OUT_ARB_PKT_CNT_EN
    ,
    parameter int PKT_CNT_W = 16
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_IN-1:0] buf_empty_i,
    input  flit_Data_noVC   flit_i [N_IN],
    output logic [N_IN-1:0] read_o,
    input  logic            downstream_on_i,
    output flit_Data_noVC   flit_o,
    output logic            valid_o,
    output logic [N_IN-1:0] grant_o,
    output logic            locked_o
`ifdef OUT_ARB_PKT_CNT_EN
    ,
    output logic [PKT_CNT_W-1:0] pkt_cnt_o
`endif
);

    localparam int PTR_W = (N_IN > 1) ? $clog2(N_IN) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t              r_state;
    logic [PTR_W-1:0]    r_rrPtr;
    logic [PTR_W-1:0]    r_grantIdx;
    logic [N_IN-1:0]     r_grant;
    flit_Data_noVC       r_flit;
    logic                r_valid;
`ifdef OUT_ARB_PKT_CNT_EN
    logic [PKT_CNT_W-1:0] r_pktCnt;
`endif

    logic [N_IN-1:0]     w_req;
    logic                w_found;
    logic [PTR_W-1:0]    w_winner;
    logic [PTR_W:0]      w_sum;
    logic [PTR_W-1:0]    w_selIdx;
    logic                w_fire;
    flit_Data_noVC       w_selFlit;
    logic                w_selTail;
    logic [PTR_W-1:0]    w_nextPtr;

    // Index to one-hot vector over the N_IN inputs
    function automatic logic [N_IN-1:0] toOneHot(input logic [PTR_W-1:0] idx);
        logic [N_IN-1:0] vec;
        vec = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

    // An unlocked input only competes when its head-of-queue flit opens a packet
    always_comb begin
        w_req = '0;
        for (int i = 0; i < N_IN; i++) begin
            w_req[i] = !buf_empty_i[i] && (flit_i[i].flit_DataLabel == HEAD);
        end
    end

    // Round-robin search: start at r_rrPtr, ascend with wrap, first requester wins
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_sum    = '0;
        for (int k = 0; k < N_IN; k++) begin
            w_sum = {1'b0, r_rrPtr} + (PTR_W + 1)'(k);
            if (w_sum >= (PTR_W + 1)'(N_IN)) begin
                w_sum = w_sum - (PTR_W + 1)'(N_IN);
            end
            if (!w_found && w_req[w_sum[PTR_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_sum[PTR_W-1:0];
            end
        end
    end

    // Pick the input served this cycle: the owner when locked, else the winner;
    // a flit moves only when the downstream buffer can take it
    always_comb begin
        if (r_state == LOCKED) begin
            w_selIdx = r_grantIdx;
            w_fire   = !buf_empty_i[r_grantIdx] && downstream_on_i;
        end else begin
            w_selIdx = w_winner;
            w_fire   = w_found && downstream_on_i;
        end
        w_selFlit = flit_i[w_selIdx];
        w_selTail = (w_selFlit.flit_DataLabel == TAIL);
        w_nextPtr = (r_grantIdx == PTR_W'(N_IN - 1)) ? '0 : r_grantIdx + 1'b1;
    end

    // Pop strobe to the served buffer; forced low while reset is asserted
    always_comb begin
        read_o = '0;
        if (w_fire && rst_n) begin
            read_o = toOneHot(w_selIdx);
        end
    end

    // Wormhole FSM with registered flit stream, grant, round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_rrPtr    <= '0;
            r_grantIdx <= '0;
            r_grant    <= '0;
            r_flit     <= '0;
            r_valid    <= 1'b0;
`ifdef OUT_ARB_PKT_CNT_EN
            r_pktCnt   <= '0;
`endif
        end else begin
            r_valid <= w_fire;
            if (w_fire) begin
                r_flit <= w_selFlit;
            end
            case (r_state)
                IDLE: begin
                    if (w_fire) begin
                        r_state    <= LOCKED;
                        r_grantIdx <= w_winner;
                        r_grant    <= toOneHot(w_winner);
                    end
                end
                LOCKED: begin
                    if (w_fire && w_selTail) begin
                        r_state <= IDLE;
                        r_grant <= '0;
                        r_rrPtr <= w_nextPtr;
`ifdef OUT_ARB_PKT_CNT_EN
                        r_pktCnt <= r_pktCnt + 1'b1;
`endif
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    assign flit_o   = r_flit;
    assign valid_o  = r_valid;
    assign grant_o  = r_grant;
    assign locked_o = (r_state == LOCKED);
`ifdef OUT_ARB_PKT_CNT_EN
    assign pkt_cnt_o = r_pktCnt;
`endif

endmodule

// File: tb/tb_output_port_arbiter.sv
// tb_output_port_arbiter: directed self-checking bench for output_port_arbiter.
// Each input buffer is modelled as a small first-word fall-through FIFO that
// pops whenever the arbiter's read_o bit for it was high at a rising edge.
// With OUT_ARB_PKT_CNT_EN defined the packet counter is built 2 bits wide.

`timescale 1ns/1ps

module tb_output_port_arbiter;
    import noc_pkg::*;

    localparam int N = 5;
`ifdef OUT_ARB_PKT_CNT_EN
    localparam int CW = 2;
    logic [CW-1:0] pkt_cnt_o;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [N-1:0]  buf_empty_i;
    flit_Data_noVC flit_i [N];
    logic [N-1:0]  read_o;
    logic          downstream_on_i;
    flit_Data_noVC flit_o;
    logic          valid_o;
    logic [N-1:0]  grant_o;
    logic          locked_o;

    flit_Data_noVC mem [N][32];
    int            rdp [N];
    int            wrp [N];
    logic [N-1:0]  rdSeen;
    int            nChecks = 0;
    int            nBad = 0;

    output_port_arbiter #(
        .N_IN(N)
`ifdef OUT_ARB_PKT_CNT_EN
        ,
        .PKT_CNT_W(CW)
`endif
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .buf_empty_i(buf_empty_i),
        .flit_i(flit_i),
        .read_o(read_o),
        .downstream_on_i(downstream_on_i),
        .flit_o(flit_o),
        .valid_o(valid_o),
        .grant_o(grant_o),
        .locked_o(locked_o)
`ifdef OUT_ARB_PKT_CNT_EN
        ,
        .pkt_cnt_o(pkt_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    function automatic flit_Data_noVC mkFlit(flit_label_t lab, int src, int seq);
        flit_Data_noVC f;
        f.flit_DataLabel = lab;
        f.data = 32'(src * 256 + seq);
        return f;
    endfunction

    task automatic refresh();
        for (int i = 0; i < N; i++) begin
            buf_empty_i[i] = (rdp[i] == wrp[i]);
            flit_i[i] = (rdp[i] == wrp[i]) ? '0 : mem[i][rdp[i]];
        end
    endtask

    task automatic push(int src, flit_label_t lab, int seq);
        mem[src][wrp[src]] = mkFlit(lab, src, seq);
        wrp[src] = wrp[src] + 1;
    endtask

    task automatic clearAll();
        for (int i = 0; i < N; i++) begin
            rdp[i] = 0;
            wrp[i] = 0;
        end
        refresh();
    endtask

    // One clock: sample read_o mid-cycle, pop the model FIFOs at the edge,
    // then settle new inputs 1 ns after the edge (outputs are valid then too)
    task automatic cycle();
        @(negedge clk);
        rdSeen = read_o;
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (rdSeen[i] && rdp[i] != wrp[i]) rdp[i] = rdp[i] + 1;
        end
        #1;
        refresh();
    endtask

    // Reset with empty buffers, ending 1 ns after a rising edge
    task automatic doReset();
        clearAll();
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        downstream_on_i = 1'b1;
        clearAll();
        for (int i = 0; i < N; i++) begin
            push(i, HEAD, 0);
            push(i, TAIL, 1);
        end
        refresh();
        #1 rst_n = 1'b0;
        @(negedge clk);
        nChecks++;
        if (read_o !== '0) begin nBad++; $display("[TB] FAIL rst_read got=%b exp=%b", read_o, 5'b0); end
        nChecks++;
        if (valid_o !== 1'b0) begin nBad++; $display("[TB] FAIL rst_valid got=%b exp=0", valid_o); end
        nChecks++;
        if (grant_o !== '0) begin nBad++; $display("[TB] FAIL rst_grant got=%b exp=00000", grant_o); end
        nChecks++;
        if (locked_o !== 1'b0) begin nBad++; $display("[TB] FAIL rst_locked got=%b exp=0", locked_o); end

        // Start a packet on input 0, then pull reset asynchronously mid-packet
        clearAll();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push(0, HEAD, 0);
        push(0, BODY, 1);
        push(0, TAIL, 2);
        refresh();
        cycle();
        nChecks++;
        if (rdSeen !== 5'b00001) begin nBad++; $display("[TB] FAIL midrst_read got=%b exp=00001", rdSeen); end
        nChecks++;
        if (locked_o !== 1'b1) begin nBad++; $display("[TB] FAIL midrst_locked_before got=%b exp=1", locked_o); end
        #2 rst_n = 1'b0;
        #1;
        nChecks++;
        if ({valid_o, locked_o, grant_o, read_o} !== '0)
            begin nBad++; $display("[TB] FAIL midrst_outputs got v=%b l=%b g=%b r=%b exp all 0", valid_o, locked_o, grant_o, read_o); end
        nChecks++;
        if (flit_o !== '0) begin nBad++; $display("[TB] FAIL midrst_flit got=%h exp=0", flit_o); end

        // Leftover BODY/TAIL of the abandoned packet must never be read
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            nChecks++;
            if (rdSeen !== '0 || valid_o !== 1'b0)
                begin nBad++; $display("[TB] FAIL leftover_body c%0d got read=%b valid=%b exp read=00000 valid=0", k, rdSeen, valid_o); end
        end
        clearAll();
    endtask

    task automatic test_single_packet();
        flit_Data_noVC expF [3];
        flit_Data_noVC expG [4];
        logic [N-1:0]  expR [4];
        expF = '{mkFlit(HEAD, 2, 0), mkFlit(BODY, 2, 1), mkFlit(TAIL, 2, 2)};
        clearAll();
        push(2, HEAD, 0);
        push(2, BODY, 1);
        push(2, TAIL, 2);
        refresh();
        for (int k = 0; k < 3; k++) begin
            cycle();
            nChecks++;
            if (rdSeen !== 5'b00100) begin nBad++; $display("[TB] FAIL single_read c%0d got=%b exp=00100", k, rdSeen); end
            nChecks++;
            if (valid_o !== 1'b1 || flit_o !== expF[k])
                begin nBad++; $display("[TB] FAIL single_flit c%0d got v=%b f=%h exp v=1 f=%h", k, valid_o, flit_o, expF[k]); end
            if (k == 0) begin
                nChecks++;
                if (grant_o !== 5'b00100 || locked_o !== 1'b1)
                    begin nBad++; $display("[TB] FAIL single_grant got g=%b l=%b exp g=00100 l=1", grant_o, locked_o); end
            end
        end
        cycle();
        nChecks++;
        if (rdSeen !== '0 || valid_o !== 1'b0)
            begin nBad++; $display("[TB] FAIL single_after got read=%b valid=%b exp 00000/0", rdSeen, valid_o); end
        cycle();
        nChecks++;
        if (locked_o !== 1'b0 || grant_o !== '0)
            begin nBad++; $display("[TB] FAIL single_unlock got l=%b g=%b exp 0/00000", locked_o, grant_o); end
        nChecks++;
        if (flit_o !== expF[2]) begin nBad++; $display("[TB] FAIL single_hold got=%h exp=%h", flit_o, expF[2]); end

        // Pointer now 3: heads on 1 and 4 -> 4 goes first, then 1, no gap
        expR = '{5'b10000, 5'b10000, 5'b00010, 5'b00010};
        expG = '{mkFlit(HEAD, 4, 0), mkFlit(TAIL, 4, 1), mkFlit(HEAD, 1, 0), mkFlit(TAIL, 1, 1)};
        push(1, HEAD, 0);
        push(1, TAIL, 1);
        push(4, HEAD, 0);
        push(4, TAIL, 1);
        refresh();
        for (int k = 0; k < 4; k++) begin
            cycle();
            nChecks++;
            if (rdSeen !== expR[k] || valid_o !== 1'b1 || flit_o !== expG[k])
                begin nBad++; $display("[TB] FAIL rr_from3 c%0d got r=%b v=%b f=%h exp r=%b v=1 f=%h", k, rdSeen, valid_o, flit_o, expR[k], expG[k]); end
        end
    endtask

    task automatic test_contention();
        logic [N-1:0]  expR [6];
        flit_Data_noVC expF [6];
        expR = '{5'b00001, 5'b00001, 5'b00010, 5'b00010, 5'b01000, 5'b01000};
        expF = '{mkFlit(HEAD, 0, 0), mkFlit(TAIL, 0, 1), mkFlit(HEAD, 1, 0),
                 mkFlit(TAIL, 1, 1), mkFlit(HEAD, 3, 0), mkFlit(TAIL, 3, 1)};
        doReset();
        push(0, HEAD, 0); push(0, TAIL, 1);
        push(1, HEAD, 0); push(1, TAIL, 1);
        push(3, HEAD, 0); push(3, TAIL, 1);
        refresh();
        for (int k = 0; k < 6; k++) begin
            cycle();
            nChecks++;
            if (rdSeen !== expR[k] || valid_o !== 1'b1 || flit_o !== expF[k])
                begin nBad++; $display("[TB] FAIL contention c%0d got r=%b v=%b f=%h exp r=%b v=1 f=%h", k, rdSeen, valid_o, flit_o, expR[k], expF[k]); end
        end
    endtask

    task automatic test_backpressure();
        logic          onV  [6];
        logic [N-1:0]  expR [6];
        logic          expV [6];
        flit_Data_noVC expF [6];
        onV  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        expR = '{5'b00001, 5'b00001, 5'b00000, 5'b00000, 5'b00001, 5'b00001};
        expV = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        expF = '{mkFlit(HEAD, 0, 0), mkFlit(BODY, 0, 1), mkFlit(BODY, 0, 1),
                 mkFlit(BODY, 0, 1), mkFlit(BODY, 0, 2), mkFlit(TAIL, 0, 3)};
        clearAll();
        push(0, HEAD, 0);
        push(0, BODY, 1);
        push(0, BODY, 2);
        push(0, TAIL, 3);
        refresh();
        for (int k = 0; k < 6; k++) begin
            downstream_on_i = onV[k];
            cycle();
            nChecks++;
            if (rdSeen !== expR[k] || valid_o !== expV[k] || flit_o !== expF[k])
                begin nBad++; $display("[TB] FAIL backpressure c%0d got r=%b v=%b f=%h exp r=%b v=%b f=%h", k, rdSeen, valid_o, flit_o, expR[k], expV[k], expF[k]); end
            if (k < 5) begin
                nChecks++;
                if (grant_o !== 5'b00001) begin nBad++; $display("[TB] FAIL backpressure_grant c%0d got=%b exp=00001", k, grant_o); end
            end
        end
        downstream_on_i = 1'b1;
    endtask

    task automatic test_starved_owner();
        logic [N-1:0]  expR [7];
        logic          expV [7];
        flit_Data_noVC expF [7];
        expR = '{5'b00010, 5'b00010, 5'b00000, 5'b00000, 5'b00010, 5'b00001, 5'b00001};
        expV = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        expF = '{mkFlit(HEAD, 1, 0), mkFlit(BODY, 1, 1), mkFlit(BODY, 1, 1), mkFlit(BODY, 1, 1),
                 mkFlit(TAIL, 1, 2), mkFlit(HEAD, 0, 0), mkFlit(TAIL, 0, 1)};
        clearAll();
        push(1, HEAD, 0);
        push(1, BODY, 1);
        push(0, HEAD, 0);
        push(0, TAIL, 1);
        refresh();
        for (int k = 0; k < 7; k++) begin
            if (k == 4) begin
                push(1, TAIL, 2);
                refresh();
            end
            cycle();
            nChecks++;
            if (rdSeen !== expR[k] || valid_o !== expV[k] || flit_o !== expF[k])
                begin nBad++; $display("[TB] FAIL starved c%0d got r=%b v=%b f=%h exp r=%b v=%b f=%h", k, rdSeen, valid_o, flit_o, expR[k], expV[k], expF[k]); end
            if (k >= 1 && k <= 3) begin
                nChecks++;
                if (grant_o !== 5'b00010) begin nBad++; $display("[TB] FAIL starved_grant c%0d got=%b exp=00010", k, grant_o); end
            end
        end
    endtask

    task automatic test_non_head();
        clearAll();
        push(3, BODY, 0);
        refresh();
        for (int k = 0; k < 3; k++) begin
            cycle();
            nChecks++;
            if (rdSeen !== '0 || valid_o !== 1'b0 || locked_o !== 1'b0)
                begin nBad++; $display("[TB] FAIL nonhead_idle c%0d got r=%b v=%b l=%b exp 00000/0/0", k, rdSeen, valid_o, locked_o); end
        end
        // Pointer is 1: input 2 is served while the stray BODY on 3 stays put
        push(2, HEAD, 0);
        push(2, TAIL, 1);
        refresh();
        for (int k = 0; k < 2; k++) begin
            cycle();
            nChecks++;
            if (rdSeen !== 5'b00100) begin nBad++; $display("[TB] FAIL nonhead_other c%0d got=%b exp=00100", k, rdSeen); end
        end
        cycle();
        nChecks++;
        if (rdSeen !== '0) begin nBad++; $display("[TB] FAIL nonhead_after got=%b exp=00000", rdSeen); end
        clearAll();
    endtask

`ifdef OUT_ARB_PKT_CNT_EN
    task automatic test_pkt_counter();
        logic [CW-1:0] expC [5];
        expC = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        doReset();
        nChecks++;
        if (pkt_cnt_o !== '0) begin nBad++; $display("[TB] FAIL pktcnt_reset got=%0d exp=0", pkt_cnt_o); end
        for (int p = 0; p < 5; p++) begin
            clearAll();
            push(p, HEAD, 0);
            push(p, TAIL, 1);
            refresh();
            cycle();
            cycle();
            nChecks++;
            if (pkt_cnt_o !== expC[p]) begin nBad++; $display("[TB] FAIL pktcnt p%0d got=%0d exp=%0d", p, pkt_cnt_o, expC[p]); end
        end
        clearAll();
    endtask
`endif

    initial begin
        downstream_on_i = 1'b1;
        clearAll();
        test_reset();
        test_single_packet();
        test_contention();
        test_backpressure();
        test_starved_owner();
        test_non_head();
`ifdef OUT_ARB_PKT_CNT_EN
        test_pkt_counter();
`endif
        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule
